// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core port, the DMA port and the single-port data RAM.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
interface dmem_arbiter_if;
    logic        core_req;
    logic        core_wr;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [3:0]  core_mask;
    logic        core_ack;
    logic [31:0] core_rdata;
    logic        core_err;

    logic        dma_req;
    logic        dma_wr;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [3:0]  dma_mask;
    logic        dma_ack;
    logic [31:0] dma_rdata;
    logic        dma_err;

    logic [31:0] mem_addr;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wr_mask;
    logic [31:0] mem_rdata;

    logic [1:0]  owner;

    modport slave (
        input  core_req, core_wr, core_addr, core_wdata, core_mask,
        input  dma_req, dma_wr, dma_addr, dma_wdata, dma_mask,
        input  mem_rdata,
        output core_ack, core_rdata, core_err,
        output dma_ack, dma_rdata, dma_err,
        output mem_addr, mem_wr_en, mem_wdata, mem_wr_mask,
        output owner
    );

    modport master (
        output core_req, core_wr, core_addr, core_wdata, core_mask,
        output dma_req, dma_wr, dma_addr, dma_wdata, dma_mask,
        output mem_rdata,
        input  core_ack, core_rdata, core_err,
        input  dma_ack, dma_rdata, dma_err,
        input  mem_addr, mem_wr_en, mem_wdata, mem_wr_mask,
        input  owner
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data RAM: issue in IDLE, respond in RESP,
// with round-robin or core-priority-with-starvation-guard selection and a range check.
module dmem_arbiter #(
    parameter int RAM_DEPTH     = 8192,
    parameter int PRIORITY_MODE = 0,
    parameter int MAX_WAIT      = 8
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    localparam int          CW       = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);
    localparam logic [31:0] DEPTH    = 32'(RAM_DEPTH);

    typedef enum logic {S_IDLE, S_RESP} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_last_dma;
    logic           r_win_dma;
    logic           r_err;
    logic [CW-1:0]  r_wait;
    logic [31:0]    r_core_rdata;
    logic [31:0]    r_dma_rdata;

    logic           w_any_req;
    logic           w_tie_dma;
    logic           w_grant_dma;
    logic           w_issue;
    logic           w_resp;
    logic           w_in_range;
    logic           w_win_wr;
    logic [31:0]    w_win_addr;
    logic [31:0]    w_win_wdata;
    logic [3:0]     w_win_mask;
    logic [31:0]    w_rd;

    // Arbitration and winner field select
    always_comb begin
        w_any_req = bus.core_req | bus.dma_req;
        if (PRIORITY_MODE == 0)
            w_tie_dma = ~r_last_dma;
        else
            w_tie_dma = (r_wait == WAIT_MAX);
        w_grant_dma = bus.dma_req & (~bus.core_req | w_tie_dma);
        w_win_wr    = w_grant_dma ? bus.dma_wr    : bus.core_wr;
        w_win_addr  = w_grant_dma ? bus.dma_addr  : bus.core_addr;
        w_win_wdata = w_grant_dma ? bus.dma_wdata : bus.core_wdata;
        w_win_mask  = w_grant_dma ? bus.dma_mask  : bus.core_mask;
        w_in_range  = (w_win_addr < DEPTH);
        w_issue     = (r_state == S_IDLE) & w_any_req & ~rst;
        w_resp      = (r_state == S_RESP) & ~rst;
        w_rd        = r_err ? 32'h0 : bus.mem_rdata;
    end

    // Next state and outputs; rst masks everything so a reset in RESP drops the ack
    always_comb begin
        w_state_nxt     = r_state;
        bus.mem_addr    = 32'h0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wdata   = 32'h0;
        bus.mem_wr_mask = 4'h0;
        bus.owner       = 2'b00;
        bus.core_ack    = 1'b0;
        bus.dma_ack     = 1'b0;
        bus.core_err    = 1'b0;
        bus.dma_err     = 1'b0;
        bus.core_rdata  = r_core_rdata;
        bus.dma_rdata   = r_dma_rdata;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) w_state_nxt = S_RESP;
                if (w_issue) begin
                    bus.mem_addr    = {w_win_addr[31:2], 2'b00};
                    bus.mem_wr_en   = w_win_wr & w_in_range;
                    bus.mem_wdata   = w_win_wdata;
                    bus.mem_wr_mask = w_win_mask;
                    bus.owner       = w_grant_dma ? 2'b10 : 2'b01;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
                if (w_resp) begin
                    bus.owner = r_win_dma ? 2'b10 : 2'b01;
                    if (r_win_dma) begin
                        bus.dma_ack   = 1'b1;
                        bus.dma_err   = r_err;
                        bus.dma_rdata = w_rd;
                    end else begin
                        bus.core_ack   = 1'b1;
                        bus.core_err   = r_err;
                        bus.core_rdata = w_rd;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_dma   <= 1'b1;
            r_win_dma    <= 1'b0;
            r_err        <= 1'b0;
            r_wait       <= '0;
            r_core_rdata <= 32'h0;
            r_dma_rdata  <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_win_dma  <= w_grant_dma;
                r_last_dma <= w_grant_dma;
                r_err      <= ~w_in_range;
            end
            // Starvation guard: counts core grants made while DMA is waiting
            if (!bus.dma_req || (w_issue && w_grant_dma))
                r_wait <= '0;
            else if (w_issue && r_wait != WAIT_MAX)
                r_wait <= r_wait + 1'b1;
            if (bus.core_ack) r_core_rdata <= w_rd;
            if (bus.dma_ack)  r_dma_rdata  <= w_rd;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: table of single transactions on a round-robin
// instance with a RAM model, plus sequences for reset, alternation and priority.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cks = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if b0 ();
    dmem_arbiter_if b1 ();

    dmem_arbiter #(.RAM_DEPTH(8192), .PRIORITY_MODE(0), .MAX_WAIT(8)) u_rr (
        .clk(clk), .rst(rst), .bus(b0)
    );
    dmem_arbiter #(.RAM_DEPTH(8192), .PRIORITY_MODE(1), .MAX_WAIT(8)) u_pri (
        .clk(clk), .rst(rst), .bus(b1)
    );

    // RAM model: registered read (old data on write), garbage beyond the array
    logic [31:0] ram [0:2047];
    logic        ram_load = 1'b1;
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 2048; i++) ram[i] <= 32'h0;
            ram[32'h1000 >> 2] <= 32'h12345678;
            ram[32'h1004 >> 2] <= 32'h11223344;
            ram[32'h1FFC >> 2] <= 32'hCAFEF00D;
        end else begin
            b0.mem_rdata <= (b0.mem_addr < 32'd8192) ? ram[b0.mem_addr[12:2]] : 32'hBADBAD00;
            if (b0.mem_wr_en && b0.mem_addr < 32'd8192)
                for (int j = 0; j < 4; j++)
                    if (b0.mem_wr_mask[j]) ram[b0.mem_addr[12:2]][8*j +: 8] <= b0.mem_wdata[8*j +: 8];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        cr, cw;
        logic [31:0] ca, cd;
        logic [3:0]  cm;
        logic        dr, dw;
        logic [31:0] da, dd;
        logic [3:0]  dm;
        logic [1:0]  own;
        logic [31:0] maddr;
        logic        wen;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic        wdma;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    vec_t v [12];

    task automatic drive0(input logic cr, cw, input logic [31:0] ca, cd, input logic [3:0] cm,
                          input logic dr, dw, input logic [31:0] da, dd, input logic [3:0] dm);
        b0.core_req = cr; b0.core_wr = cw; b0.core_addr = ca; b0.core_wdata = cd; b0.core_mask = cm;
        b0.dma_req = dr;  b0.dma_wr = dw;  b0.dma_addr = da;  b0.dma_wdata = dd;  b0.dma_mask = dm;
    endtask

    initial begin
        logic [31:0] last_c, last_d;
        logic        got;
        last_c = 32'h0;
        last_d = 32'h0;
        drive0(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        b1.core_req = 0; b1.core_wr = 0; b1.core_addr = 32'h100; b1.core_wdata = 0; b1.core_mask = 0;
        b1.dma_req = 0;  b1.dma_wr = 0;  b1.dma_addr = 32'h200;  b1.dma_wdata = 0;  b1.dma_mask = 0;
        b1.mem_rdata = 32'h0;

        //        cr cw ca            cd            cm     dr dw da            dd            dm     own    maddr         wen wmask  wdata         wdma rd            err
        v[0]  = '{1, 0, 32'h1000,     32'h0,        4'h0,  0, 0, 32'h0,        32'h0,        4'h0,  2'b01, 32'h1000,     0,  4'h0,  32'h0,        0,   32'h12345678, 0};
        v[1]  = '{0, 0, 32'h0,        32'h0,        4'h0,  1, 0, 32'h1004,     32'h0,        4'h0,  2'b10, 32'h1004,     0,  4'h0,  32'h0,        1,   32'h11223344, 0};
        v[2]  = '{1, 1, 32'h1004,     32'h0000AB00, 4'h2,  0, 0, 32'h0,        32'h0,        4'h0,  2'b01, 32'h1004,     1,  4'h2,  32'h0000AB00, 0,   32'h11223344, 0};
        v[3]  = '{1, 0, 32'h1004,     32'h0,        4'h0,  0, 0, 32'h0,        32'h0,        4'h0,  2'b01, 32'h1004,     0,  4'h0,  32'h0,        0,   32'h1122AB44, 0};
        v[4]  = '{0, 0, 32'h0,        32'h0,        4'h0,  1, 1, 32'h2000,     32'hDEADBEEF, 4'hF,  2'b10, 32'h2000,     0,  4'hF,  32'hDEADBEEF, 1,   32'h0,        1};
        v[5]  = '{0, 0, 32'h0,        32'h0,        4'h0,  1, 0, 32'h1004,     32'h0,        4'h0,  2'b10, 32'h1004,     0,  4'h0,  32'h0,        1,   32'h1122AB44, 0};
        v[6]  = '{1, 0, 32'h1007,     32'h0,        4'h0,  0, 0, 32'h0,        32'h0,        4'h0,  2'b01, 32'h1004,     0,  4'h0,  32'h0,        0,   32'h1122AB44, 0};
        v[7]  = '{1, 0, 32'h1FFC,     32'h0,        4'h0,  0, 0, 32'h0,        32'h0,        4'h0,  2'b01, 32'h1FFC,     0,  4'h0,  32'h0,        0,   32'hCAFEF00D, 0};
        v[8]  = '{1, 0, 32'hFFFFFFFC, 32'h0,        4'h0,  0, 0, 32'h0,        32'h0,        4'h0,  2'b01, 32'hFFFFFFFC, 0,  4'h0,  32'h0,        0,   32'h0,        1};
        v[9]  = '{1, 0, 32'h1000,     32'h0,        4'h0,  1, 0, 32'h1FFC,     32'h0,        4'h0,  2'b10, 32'h1FFC,     0,  4'h0,  32'h0,        1,   32'hCAFEF00D, 0};
        v[10] = '{1, 1, 32'h1000,     32'hA5A5A5A5, 4'hF,  1, 0, 32'h0,        32'h0,        4'h0,  2'b01, 32'h1000,     1,  4'hF,  32'hA5A5A5A5, 0,   32'h12345678, 0};
        v[11] = '{1, 0, 32'h1000,     32'h0,        4'h0,  0, 0, 32'h0,        32'h0,        4'h0,  2'b01, 32'h1000,     0,  4'h0,  32'h0,        0,   32'hA5A5A5A5, 0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        ram_load = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_core_ack", b0.core_ack, 0);
        chk("rst_dma_ack", b0.dma_ack, 0);
        chk("rst_errs", {b0.core_err, b0.dma_err}, 0);
        chk("rst_owner", b0.owner, 0);
        chk("rst_mem", {b0.mem_wr_en, b0.mem_wr_mask}, 0);
        chk("rst_mem_addr", b0.mem_addr, 0);
        chk("rst_mem_wdata", b0.mem_wdata, 0);
        chk("rst_core_rdata", b0.core_rdata, 0);
        chk("rst_dma_rdata", b0.dma_rdata, 0);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive0(v[i].cr, v[i].cw, v[i].ca, v[i].cd, v[i].cm, v[i].dr, v[i].dw, v[i].da, v[i].dd, v[i].dm);
            #1;
            chk($sformatf("v%0d_owner", i), b0.owner, v[i].own);
            chk($sformatf("v%0d_mem_addr", i), b0.mem_addr, v[i].maddr);
            chk($sformatf("v%0d_mem_wr_en", i), b0.mem_wr_en, v[i].wen);
            chk($sformatf("v%0d_mem_wr_mask", i), b0.mem_wr_mask, v[i].wmask);
            chk($sformatf("v%0d_mem_wdata", i), b0.mem_wdata, v[i].wdata);
            @(negedge clk);
            #1;
            chk($sformatf("v%0d_core_ack", i), b0.core_ack, !v[i].wdma);
            chk($sformatf("v%0d_dma_ack", i), b0.dma_ack, v[i].wdma);
            if (v[i].wdma) begin
                chk($sformatf("v%0d_dma_rdata", i), b0.dma_rdata, v[i].rd);
                chk($sformatf("v%0d_dma_err", i), b0.dma_err, v[i].err);
                chk($sformatf("v%0d_core_hold", i), b0.core_rdata, last_c);
                last_d = v[i].rd;
            end else begin
                chk($sformatf("v%0d_core_rdata", i), b0.core_rdata, v[i].rd);
                chk($sformatf("v%0d_core_err", i), b0.core_err, v[i].err);
                chk($sformatf("v%0d_dma_hold", i), b0.dma_rdata, last_d);
                last_c = v[i].rd;
            end
            drive0(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end

        // Request withdrawn during RESP: the transaction still completes
        @(negedge clk);
        drive0(1, 0, 32'h1004, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        b0.core_req = 1'b0;
        #1;
        chk("drop_core_ack", b0.core_ack, 1);
        chk("drop_core_rdata", b0.core_rdata, 32'h1122AB44);

        // Reset arriving in RESP kills the ack; next request served normally
        @(negedge clk);
        drive0(1, 0, 32'h1000, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid_no_ack", b0.core_ack, 0);
        b0.core_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstmid_owner", b0.owner, 0);
        chk("rstmid_no_ack2", b0.core_ack, 0);
        drive0(1, 0, 32'h1FFC, 0, 0, 0, 0, 0, 0, 0);
        got = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            if (b0.core_ack && !got) begin
                got = 1'b1;
                chk("rstmid_rdata", b0.core_rdata, 32'hCAFEF00D);
            end
        end
        chk("rstmid_served", got, 1);
        drive0(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);

        // Round-robin alternation from reset with both writes held
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive0(1, 1, 32'h0, 32'h1, 4'hF, 1, 1, 32'h4, 32'h2, 4'hF);
        for (int i = 0; i < 12; i++) begin
            #1;
            if (i % 2 == 0) begin
                chk($sformatf("alt%0d_owner", i), b0.owner, ((i / 2) % 2) ? 2'b10 : 2'b01);
            end else begin
                chk($sformatf("alt%0d_core_ack", i), b0.core_ack, (i % 4) == 1);
                chk($sformatf("alt%0d_dma_ack", i), b0.dma_ack, (i % 4) == 3);
            end
            @(negedge clk);
        end
        drive0(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Core priority: 8 core grants, then DMA forced, repeating
        @(negedge clk);
        b1.core_req = 1'b1;
        b1.dma_req  = 1'b1;
        for (int i = 0; i < 36; i++) begin
            #1;
            if (i % 2 == 0) begin
                chk($sformatf("pri%0d_owner", i), b1.owner, ((i / 2) % 9 == 8) ? 2'b10 : 2'b01);
            end else begin
                chk($sformatf("pri%0d_dma_ack", i), b1.dma_ack, ((i / 2) % 9) == 8);
                chk($sformatf("pri%0d_core_ack", i), b1.core_ack, ((i / 2) % 9) != 8);
            end
            @(negedge clk);
        end
        b1.core_req = 1'b0;
        b1.dma_req  = 1'b0;

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", cks, errs);
        $finish;
    end
endmodule
